// File: rtl/logic_op_sequencer.sv
// logic_op_sequencer: queues logic-op commands, drives an external
// logic unit and returns one captured result per command.
module logic_op_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_a,
  input  logic             cmd_b,
  input  logic [1:0]       cmd_op,
  output logic             alu_a,
  output logic             alu_b,
  output logic             alu_s1,
  output logic             alu_s0,
  input  logic             alu_o,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_data,
  output logic [1:0]       res_op,
  output logic [CNT_W-1:0] op_count,
  output logic             busy
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef struct packed {
    logic       a;
    logic       b;
    logic [1:0] op;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    SAMPLE,
    OUT
  } state_t;

  state_t          state;
  cmd_t            mem [FIFO_DEPTH];
  cmd_t            head;
  cmd_t            wr_cmd;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic [1:0]      op_q;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;

  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  assign head      = mem[rd_ptr];
  assign busy      = (state != IDLE) || !empty;

  assign wr_cmd.a  = cmd_a;
  assign wr_cmd.b  = cmd_b;
  assign wr_cmd.op = cmd_op;

  // A pop only happens where the FSM is ready to issue a new command;
  // emptiness is judged before this edge's push, so there is no bypass.
  always_comb begin
    pop = 1'b0;
    unique case (1'b1)
      (state == IDLE): pop = !empty;
      (state == OUT):  pop = !empty && res_ready;
      default:         pop = 1'b0;
    endcase
  end

  // Command storage: write the incoming command at the tail.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      mem[wr_ptr] <= wr_cmd;
    end
  end

  // Pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

  // Occupancy: simultaneous push and pop leave it unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      unique case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Issue / sample / present sequencer with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      alu_a     <= 1'b0;
      alu_b     <= 1'b0;
      alu_s1    <= 1'b0;
      alu_s0    <= 1'b0;
      op_q      <= 2'b00;
      res_valid <= 1'b0;
      res_data  <= 1'b0;
      res_op    <= 2'b00;
      op_count  <= '0;
    end else begin
      if (pop) begin
        alu_a  <= head.a;
        alu_b  <= head.b;
        alu_s1 <= head.op[1];
        alu_s0 <= head.op[0];
        op_q   <= head.op;
      end
      unique case (state)
        IDLE: begin
          if (pop) begin
            state <= SAMPLE;
          end
        end
        SAMPLE: begin
          res_data  <= alu_o;
          res_op    <= op_q;
          res_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            op_count  <= op_count + CNT_W'(1);
            state     <= pop ? SAMPLE : IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_logic_op_sequencer.sv
// tb_logic_op_sequencer: random and directed stimulus against a
// transaction-level scoreboard of the sequencer.
module tb_logic_op_sequencer;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_a = 1'b0;
  logic       cmd_b = 1'b0;
  logic [1:0] cmd_op = 2'b00;
  logic       res_ready = 1'b0;

  logic       cmd_ready, alu_a, alu_b, alu_s1, alu_s0, alu_o;
  logic       res_valid, res_data, busy;
  logic [1:0] res_op;
  logic [7:0] op_count;

  logic       c2_cmd_ready, c2_alu_a, c2_alu_b, c2_alu_s1, c2_alu_s0;
  logic       c2_alu_o, c2_res_valid, c2_res_data, c2_busy;
  logic [1:0] c2_res_op;
  logic [1:0] c2_op_count;

  int checks = 0;
  int errors = 0;

  logic [2:0] exq[$];
  int         outstanding = 0;
  int         consumed = 0;
  logic       hold = 1'b0;
  logic       hold_data = 1'b0;
  logic [1:0] hold_op = 2'b00;

  always #5 clk = ~clk;

  function automatic logic ref_op(input logic a, input logic b,
                                  input logic [1:0] op);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~a;
    endcase
  endfunction

  assign alu_o    = ref_op(alu_a, alu_b, {alu_s1, alu_s0});
  assign c2_alu_o = ref_op(c2_alu_a, c2_alu_b, {c2_alu_s1, c2_alu_s0});

  logic_op_sequencer #(.FIFO_DEPTH(DEPTH), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s1(alu_s1), .alu_s0(alu_s0),
    .alu_o(alu_o),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_op(res_op),
    .op_count(op_count), .busy(busy)
  );

  logic_op_sequencer #(.FIFO_DEPTH(DEPTH), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(c2_cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .alu_a(c2_alu_a), .alu_b(c2_alu_b),
    .alu_s1(c2_alu_s1), .alu_s0(c2_alu_s0),
    .alu_o(c2_alu_o),
    .res_valid(c2_res_valid), .res_ready(res_ready),
    .res_data(c2_res_data), .res_op(c2_res_op),
    .op_count(c2_op_count), .busy(c2_busy)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive at negedge, check and update the model, then
  // wait for the following negedge.
  task automatic step(input logic v, input logic a, input logic b,
                      input logic [1:0] op, input logic rr);
    logic       exp_ready;
    logic [2:0] e;
    cmd_valid = v;
    cmd_a     = a;
    cmd_b     = b;
    cmd_op    = op;
    res_ready = rr;
    #1;
    exp_ready = (outstanding != DEPTH + 1);
    chk("cmd_ready", cmd_ready, exp_ready);
    chk("busy", busy, outstanding != 0);
    chk("op_count", op_count, consumed % 256);
    chk("op_count_w2", c2_op_count, consumed % 4);
    chk("res_valid_w2", c2_res_valid, res_valid);
    chk("busy_w2", c2_busy, busy);
    if (hold) begin
      chk("hold_valid", res_valid, 1);
      chk("hold_data", res_data, hold_data);
      chk("hold_op", res_op, hold_op);
    end
    if (res_valid) begin
      if (exq.size() == 0) begin
        chk("spurious_res", res_valid, 0);
      end else if (rr) begin
        e = exq.pop_front();
        chk("res_data", res_data, e[2]);
        chk("res_op", res_op, e[1:0]);
        consumed++;
        outstanding--;
      end
    end
    hold      = res_valid && !rr;
    hold_data = res_data;
    hold_op   = res_op;
    if (v && exp_ready) begin
      exq.push_back({ref_op(a, b, op), op});
      outstanding++;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic rr);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 2'b00, rr);
  endtask

  task automatic rnd_cmd(input logic rr);
    step(1'b1, 1'($urandom), 1'($urandom), 2'($urandom), rr);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_res_op", res_op, 0);
    chk("rst_op_count", op_count, 0);
    chk("rst_alu", {alu_a, alu_b, alu_s1, alu_s0}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    exq.delete();
    outstanding = 0;
    consumed    = 0;
    hold        = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    do_reset();

    // single XOR command, latency and result
    step(1'b1, 1'b1, 1'b0, 2'b10, 1'b1);
    chk("lat_alu_k", {alu_a, alu_b, alu_s1, alu_s0}, 4'b0000);
    chk("lat_valid_k", res_valid, 0);
    idle(1, 1'b1);
    chk("lat_alu_k1", {alu_a, alu_b, alu_s1, alu_s0}, 4'b1010);
    chk("lat_valid_k1", res_valid, 0);
    idle(1, 1'b1);
    chk("lat_valid_k2", res_valid, 1);
    chk("single_data", res_data, 1);
    chk("single_op", res_op, 2'b10);
    idle(1, 1'b1);
    chk("single_count", op_count, 1);
    idle(2, 1'b1);

    // all four ops on a=b=1, back to back
    for (int k = 0; k < 4; k++) step(1'b1, 1'b1, 1'b1, 2'(k), 1'b1);
    idle(10, 1'b1);
    chk("four_count", op_count, 5);
    chk("alu_hold", {alu_a, alu_b, alu_s1, alu_s0}, 4'b1111);

    // fill with consumer stalled; sixth command refused
    for (int k = 0; k < 6; k++) rnd_cmd(1'b0);
    chk("full_ready", cmd_ready, 0);
    idle(4, 1'b0);
    idle(15, 1'b1);
    chk("drain_busy", busy, 0);

    // push and pop on the same edge with two queued
    for (int k = 0; k < 3; k++) rnd_cmd(1'b0);
    idle(2, 1'b0);
    rnd_cmd(1'b1);
    idle(15, 1'b1);

    // reset while presenting with three queued
    for (int k = 0; k < 4; k++) rnd_cmd(1'b0);
    idle(3, 1'b0);
    do_reset();
    idle(6, 1'b1);
    rnd_cmd(1'b1);
    idle(6, 1'b1);

    // random traffic
    for (int k = 0; k < 400; k++) begin
      step($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom),
           2'($urandom), $urandom_range(0, 2) != 0);
    end
    idle(20, 1'b1);

    // streaming long enough to wrap the 8-bit counter
    for (int k = 0; k < 560; k++) rnd_cmd(1'b1);
    idle(20, 1'b1);
    chk("end_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
